// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial load controller: the FSM state
// encoding, the default word width and a width-aware bit-reverse helper.
package serial_pkg;

    // Controller FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default word width / shift-register length.
    localparam int DEFAULT_WIDTH = 4;

    // Widest word the bit-reverse helper can handle.
    localparam int MAX_WIDTH = 64;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(
        input logic [MAX_WIDTH-1:0] v,
        input int unsigned          w
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < int'(w)) begin
                r[int'(w) - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_load_ctrl_sr_shift.sv
// Serial-in shift register, shifting toward the MSB: Q <= {Q[WIDTH-2:0], D}.
// Synchronous clear (also driven by reset) has priority over the shift enable.
module sr_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             D,
    output logic [WIDTH-1:0] Q
);

    // Clear wins over shift; otherwise shift one bit in when enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= {Q[WIDTH-2:0], D};
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Sequencer that accepts a parallel word, clears the owned shift register,
// shifts the word in one bit per clock and returns the reassembled word over
// an output valid/ready handshake.
//
// Build option MSB_FIRST_EN:
//   defined   - shadow word is shifted MSB first, so Q ends equal to the word.
//   undefined - shadow word is shifted LSB first, Q ends bit-reversed and the
//               result is reversed back before it is presented.
// Handshake timing is identical in both builds.
module serial_load_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             busy
);

    localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_load_ctrl: WIDTH must be in 2..%0d", MAX_WIDTH);
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             bit_sel;
    logic             sr_clr;
    logic             sr_en;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] recovered;

    // Bit order of the serial stream and the matching recovery of the word.
`ifdef MSB_FIRST_EN
    assign bit_sel   = shadow[LAST_CNT - cnt];
    assign recovered = q_next;
`else
    assign bit_sel   = shadow[cnt];
    assign recovered = WIDTH'(bit_reverse(MAX_WIDTH'(q_next), WIDTH));
`endif

    // Serial bit is only driven while shifting; it is zero otherwise.
    assign D      = (state == SHIFT) ? bit_sel : 1'b0;
    assign sr_en  = (state == SHIFT);
    assign sr_clr = rst | (state == CLEAR);

    // Register contents after the shift happening this cycle; on the last
    // shift this is the final content, captured into out_data so the result
    // is registered the same cycle out_valid rises.
    assign q_next = {Q[WIDTH-2:0], D};

    // Control decodes: accept only in IDLE and never while reset is held.
    assign in_ready = (state == IDLE) & ~rst;
    assign busy     = (state != IDLE);

    sr_shift #(
        .WIDTH (WIDTH)
    ) u_sr_shift (
        .clk (clk),
        .rst (rst),
        .clr (sr_clr),
        .en  (sr_en),
        .D   (D),
        .Q   (Q)
    );

    // Load sequencer: IDLE -> CLEAR -> SHIFT x WIDTH -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shadow <= in_data;
                        cnt    <= '0;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= recovered;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Directed self-checking bench for serial_load_ctrl (WIDTH = 4).
module tb_serial_load_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       D;
    logic [3:0] Q;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    serial_load_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .D         (D),
        .Q         (Q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed output handshakes.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one word for exactly one edge.
    task automatic send(input logic [3:0] w);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the cycle right after accept; waits for out_valid, checks
    // latency, data and optionally the serial bit stream (first bit in [3]).
    task automatic wait_out(input string tag, input logic [3:0] exp,
                            input bit chk_d, input logic [3:0] exp_d);
        int n;
        logic [3:0] ds;
        n  = 1;
        ds = 4'b0000;
        while (!out_valid && n < 20) begin
            if (n >= 2 && n <= 5) ds[5-n] = D;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 6);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        if (chk_d) check({tag, "_dseq"}, ds, exp_d);
    endtask

    initial begin
        int acc_t[2];
        int na;
        int hs0;
        bit seen;
        logic [3:0] outs[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        out_ready = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_in_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_q", Q, 0);
        check("rst_busy", busy, 0);
        check("rst_d", D, 0);

        // Single load of 1010
        out_ready = 1'b1;
        send(4'b1010);
        check("single_busy", busy, 1);
        check("single_in_ready", in_ready, 0);
        check("single_clear_d", D, 0);
`ifdef MSB_FIRST_EN
        wait_out("single", 4'b1010, 1'b1, 4'b1010);
        check("single_q", Q, 4'b1010);
`else
        wait_out("single", 4'b1010, 1'b1, 4'b0101);
        check("single_q", Q, 4'b0101);
`endif
        check("single_done_d", D, 0);
        tick();
        check("single_idle_valid", out_valid, 0);
        check("single_idle_ready", in_ready, 1);

        // Backpressure
        out_ready = 1'b0;
        send(4'b1010);
        wait_out("bp", 4'b1010, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'b0110;
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 4'b1010);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        send(4'b0110);
        wait_out("bp2", 4'b0110, 1'b0, 4'b0000);
        tick();

        // Reset in the second SHIFT cycle
        send(4'b1111);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_q", Q, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("mid_rst_no_output", seen, 0);
        send(4'b0001);
        wait_out("post_rst", 4'b0001, 1'b0, 4'b0000);
        tick();

        // Back-to-back with in_valid held high
        na       = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        in_valid = 1'b1;
        in_data  = 4'b0011;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && out_ready) outs.push_back(out_data);
            if (in_valid && in_ready && na < 2) begin
                acc_t[na] = c;
                na++;
            end
            tick();
            if (na == 1) in_data = 4'b1100;
            if (na == 2) in_valid = 1'b0;
        end
        check("b2b_accepts", na, 2);
        check("b2b_spacing", acc_t[1] - acc_t[0], 7);
        check("b2b_out_count", outs.size(), 2);
        if (outs.size() == 2) begin
            check("b2b_out0", outs[0], 4'b0011);
            check("b2b_out1", outs[1], 4'b1100);
        end

        // Exhaustive loopback
        hs0 = hs_cnt;
        for (int w = 0; w < 16; w++) begin
            send(4'(w));
            wait_out("loop", 4'(w), 1'b0, 4'b0000);
            tick();
            check("loop_no_extra", out_valid, 0);
        end
        check("loop_pulses", hs_cnt - hs0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
